// File: rtl/display_capture.sv
// Rebuilds the four hex digits and decimal points shown on a multiplexed 7-segment bus.
// Optional stale-bus timeout is enabled by defining CAPTURE_TIMEOUT_EN.
module display_capture #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter int unsigned TIMEOUT_BITS   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] en_disp,
  input  logic [7:0] digit_out,
  output logic [3:0] hex_0_out,
  output logic [3:0] hex_1_out,
  output logic [3:0] hex_2_out,
  output logic [3:0] hex_3_out,
  output logic [3:0] dp_out,
  output logic [3:0] seg_err,
  output logic       frame_valid,
  output logic       timeout
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic {StWait, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [11:0]     bus_q, prev_q;
  logic [3:0]      en_q;
  logic [7:0]      seg;
  logic            changed, one_hot, capture;
  logic [1:0]      idx;
  logic [4:0]      dec;
  logic [3:0]      stage_hex [4];
  logic [3:0]      stage_dp, stage_err;
  logic [3:0]      seen_q, seen_d;
  logic            commit_q;
  logic            stale;

  // Returns {err, value}; dp is not part of the pattern.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = 5'h00;
      7'h06:   decode = 5'h01;
      7'h5B:   decode = 5'h02;
      7'h4F:   decode = 5'h03;
      7'h66:   decode = 5'h04;
      7'h6D:   decode = 5'h05;
      7'h7D:   decode = 5'h06;
      7'h07:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h6F:   decode = 5'h09;
      7'h77:   decode = 5'h0A;
      7'h7C:   decode = 5'h0B;
      7'h39:   decode = 5'h0C;
      7'h5E:   decode = 5'h0D;
      7'h79:   decode = 5'h0E;
      7'h71:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  assign en_q    = bus_q[11:8];
  assign seg     = SEG_ACTIVE_LOW ? ~bus_q[7:0] : bus_q[7:0];
  assign changed = (bus_q != prev_q);
  assign one_hot = (en_q != 4'b0000) && ((en_q & (en_q - 4'd1)) == 4'b0000);
  assign dec     = decode(seg[6:0]);

  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (en_q[i]) idx = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StWait: begin
        if (changed) begin
          cnt_d = '0;
        end else begin
          if (cnt_q == CntMax && one_hot) begin
            capture = 1'b1;
            state_d = StHold;
          end
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (changed) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      default: state_d = StWait;
    endcase
  end

  always_comb begin
    seen_d = seen_q;
    if (commit_q) seen_d = 4'b0000;
    if (stale && !capture) seen_d = 4'b0000;
    if (capture) seen_d = seen_d | en_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q   <= '0;
      prev_q  <= '0;
      state_q <= StWait;
      cnt_q   <= '0;
    end else begin
      bus_q   <= {en_disp, digit_out};
      prev_q  <= bus_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stage_hex[i] <= 4'h0;
      stage_dp    <= '0;
      stage_err   <= '0;
      seen_q      <= '0;
      commit_q    <= 1'b0;
      frame_valid <= 1'b0;
      hex_0_out   <= '0;
      hex_1_out   <= '0;
      hex_2_out   <= '0;
      hex_3_out   <= '0;
      dp_out      <= '0;
      seg_err     <= '0;
    end else begin
      if (capture) begin
        stage_hex[idx] <= dec[3:0];
        stage_dp[idx]  <= seg[7];
        stage_err[idx] <= dec[4];
      end
      seen_q      <= seen_d;
      commit_q    <= capture && ((seen_q | en_q) == 4'hF);
      frame_valid <= commit_q;
      if (commit_q) begin
        hex_0_out <= stage_hex[0];
        hex_1_out <= stage_hex[1];
        hex_2_out <= stage_hex[2];
        hex_3_out <= stage_hex[3];
        dp_out    <= stage_dp;
        seg_err   <= stage_err;
      end
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] tcnt_q;

  assign stale   = &tcnt_q;
  assign timeout = stale;

  // Saturates so the flag holds until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if (capture) begin
      tcnt_q <= '0;
    end else if (!stale) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end
`else
  localparam bit TimeoutWidthOk = (TIMEOUT_BITS > 0);

  assign stale   = 1'b0 & TimeoutWidthOk;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_display_capture.sv
// Randomized scoreboard bench for display_capture; the model works on held bus periods.
module tb_display_capture;

  localparam int unsigned S = 4;
`ifdef CAPTURE_TIMEOUT_EN
  localparam int unsigned TB_TO = 6;
`else
  localparam int unsigned TB_TO = 16;
`endif

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  err;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en_disp;
  logic [7:0] digit_out;
  logic [3:0] hex_0_out, hex_1_out, hex_2_out, hex_3_out;
  logic [3:0] dp_out, seg_err;
  logic       frame_valid, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int frames_exp = 0;
  int frames_got = 0;
  int since_cap  = 0;

  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  frame_t      exp_q [$];
  logic [15:0] m_hex;
  logic [3:0]  m_dp, m_err, m_seen;
  logic [11:0] run_v;
  int          run_len;

  always #5 clk = ~clk;

  display_capture #(
    .SETTLE_CYCLES (S),
    .SEG_ACTIVE_LOW(1'b0),
    .TIMEOUT_BITS  (TB_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_disp    (en_disp),
    .digit_out  (digit_out),
    .hex_0_out  (hex_0_out),
    .hex_1_out  (hex_1_out),
    .hex_2_out  (hex_2_out),
    .hex_3_out  (hex_3_out),
    .dp_out     (dp_out),
    .seg_err    (seg_err),
    .frame_valid(frame_valid),
    .timeout    (timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A bus value held stably long enough is one capture of the digit it names.
  task automatic model_capture(input logic [11:0] v);
    logic [3:0] en;
    logic [3:0] val;
    logic       hit;
    int         n;
    en = v[11:8];
    if ($countones(en) != 1) return;
    n   = 0;
    for (int i = 0; i < 4; i++) if (en[i]) n = i;
    val = 4'h0;
    hit = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (seg_tab[k] == v[6:0]) begin
        val = 4'(k);
        hit = 1'b1;
      end
    end
    m_hex[4*n +: 4] = val;
    m_dp[n]         = v[7];
    m_err[n]        = ~hit;
    m_seen          = m_seen | en;
    since_cap       = 0;
    if (m_seen == 4'hF) begin
      exp_q.push_back('{hex: m_hex, dp: m_dp, err: m_err});
      frames_exp++;
      m_seen = 4'h0;
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [7:0] seg, input int len);
    for (int i = 0; i < len; i++) begin
      if ({en, seg} != run_v) begin
        run_v   = {en, seg};
        run_len = 0;
      end
      en_disp   = en;
      digit_out = seg;
      @(posedge clk);
      #1;
      run_len++;
      since_cap++;
      if (run_len == S + 1) model_capture(run_v);
    end
  endtask

  task automatic show(input int d, input int v, input logic dp, input int len);
    drive(4'(1 << d), {dp, seg_tab[v]}, len);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_hex"}, {16'h0, hex_3_out, hex_2_out, hex_1_out, hex_0_out}, 32'h0);
    check({tag, "_dp"}, {28'h0, dp_out}, 32'h0);
    check({tag, "_seg_err"}, {28'h0, seg_err}, 32'h0);
    check({tag, "_frame_valid"}, {31'h0, frame_valid}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      frames_got++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'h1, 32'h0);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        check("frame_hex", {16'h0, hex_3_out, hex_2_out, hex_1_out, hex_0_out}, {16'h0, e.hex});
        check("frame_dp", {28'h0, dp_out}, {28'h0, e.dp});
        check("frame_seg_err", {28'h0, seg_err}, {28'h0, e.err});
      end
    end
  end

  initial begin
    int vals [4] = '{1, 5, 10, 15};
    int base;
    rst       = 1'b1;
    en_disp   = 4'h0;
    digit_out = 8'h00;
    m_hex = '0; m_dp = '0; m_err = '0; m_seen = '0;
    run_v = '0; run_len = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("in_reset");
    @(negedge clk);
    rst = 1'b0;

    drive(4'h0, 8'h00, 20);
    check_zero_outputs("idle");
    check("idle_timeout", {31'h0, timeout}, 32'h0);
    check("idle_no_frames", frames_got, 0);

    // Steady 1,5,A,F frames with dp pattern 1010.
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++) show(d, vals[d], d[0], 8);
    drive(4'h0, 8'h00, 4);
    check("steady_hex", {16'h0, hex_3_out, hex_2_out, hex_1_out, hex_0_out}, 32'hFA51);
    check("steady_dp", {28'h0, dp_out}, 32'b1010);
    check("steady_err", {28'h0, seg_err}, 32'h0);
    check("steady_frames", frames_got, 3);

    // Too short to settle: nothing captured.
    base = frames_got;
    for (int r = 0; r < 4; r++)
      for (int d = 0; d < 4; d++) show(d, 8, 1'b1, S - 1);
    drive(4'h0, 8'h00, 6);
    check("glitch_frames", frames_got, base);

    // Blank digit 2 still completes a frame, flagged as undecodable.
    show(0, 1, 1'b0, 8);
    show(1, 5, 1'b1, 8);
    drive(4'b0100, 8'h00, 8);
    show(3, 15, 1'b1, 8);
    drive(4'h0, 8'h00, 4);
    check("blank_hex2", {28'h0, hex_2_out}, 32'h0);
    check("blank_seg_err", {28'h0, seg_err}, 32'b0100);

    // Multi-hot enable is ignored; a lone digit 3 never makes a frame.
    base = frames_got;
    drive(4'b0011, {1'b0, seg_tab[7]}, 20);
    show(3, 9, 1'b0, 8);
    drive(4'h0, 8'h00, 10);
    check("multihot_frames", frames_got, base);
    show(0, 2, 1'b0, 8);
    show(1, 3, 1'b0, 8);
    show(2, 4, 1'b0, 8);
    drive(4'h0, 8'h00, 4);
    check("multihot_completion", frames_got, base + 1);

    // Asynchronous reset mid-frame discards the partial stage.
    show(0, 6, 1'b1, 8);
    show(1, 7, 1'b1, 8);
    en_disp   = 4'h0;
    digit_out = 8'h00;
    rst       = 1'b1;
    #2;
    check_zero_outputs("mid_reset");
    @(negedge clk);
    rst    = 1'b0;
    m_seen = 4'h0;
    run_v  = '0;
    run_len = 0;
    show(2, 12, 1'b0, 8);
    show(3, 13, 1'b0, 8);
    drive(4'h0, 8'h00, 6);
    check("after_reset_no_frame", frames_got, frames_exp);

`ifdef CAPTURE_TIMEOUT_EN
    show(0, 3, 1'b0, 8);
    show(1, 3, 1'b0, 8);
    drive(4'h0, 8'h00, 70);
    check("timeout_set", {31'h0, timeout}, 32'h1);
    m_seen = 4'h0;
    show(2, 4, 1'b0, 8);
    check("timeout_cleared", {31'h0, timeout}, 32'h0);
    show(3, 5, 1'b0, 8);
    show(0, 6, 1'b0, 8);
    show(1, 7, 1'b0, 8);
    drive(4'h0, 8'h00, 4);
`endif

    // Random periods of random length, patterns and enables.
    for (int p = 0; p < 400; p++) begin
      logic [3:0] en;
      logic [7:0] sg;
      int         len;
      int         r;
      r  = $urandom_range(0, 7);
      if (r == 0)      en = 4'h0;
      else if (r == 1) en = 4'($urandom);
      else             en = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) sg = {1'($urandom), 7'($urandom)};
      else sg = {1'($urandom), seg_tab[$urandom_range(0, 15)]};
      len = $urandom_range(1, S + 4);
      if (since_cap > 30) begin
        en  = 4'(1 << $urandom_range(0, 3));
        len = S + 2;
      end
      drive(en, sg, len);
    end
    drive(4'h0, 8'h00, 20);

    check("queue_drained", exp_q.size(), 0);
    check("frame_count", frames_got, frames_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
